// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field positions, FSM states.
package cp0_pkg;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;

    localparam int unsigned STATUS_IE = 0;
    localparam int unsigned IM_LSB    = 8;
    localparam int unsigned EXC_LSB   = 2;
    localparam int unsigned EXC_W     = 5;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_HANDLER = 1'b1
    } cp0_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-bit two-flop synchroniser followed by a rising-edge detector.
module irq_sync_edge #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] rise_c
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= '0;
            sync   <= '0;
            sync_q <= '0;
        end else begin
            meta   <= async_in;
            sync   <= meta;
            sync_q <= sync;
        end
    end

    assign rise_c = sync & ~sync_q;

endmodule

// File: rtl/cp0_trap_unit.sv
// Coprocessor-0 responder: Status/Cause/EPC, interrupt latching and trap/eret PC redirect.
module cp0_trap_unit
    import cp0_pkg::*;
#(
    parameter int unsigned IRQ_COUNT    = 3,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instrValid,
    input  logic                 mtc0,
    input  logic                 mfc0,
    input  logic                 eret,
    input  logic                 syscall,
    input  logic [4:0]           cp0Addr,
    input  logic [31:0]          writeData,
    input  logic [31:0]          pcNext,
    input  logic [IRQ_COUNT-1:0] irq,
    output logic [31:0]          readData,
    output logic                 trap,
    output logic [31:0]          trapTarget,
    output logic                 inHandler
);

    cp0_state_e           state;
    logic                 ie;
    logic [IRQ_COUNT-1:0] im;
    logic [IRQ_COUNT-1:0] pending;
    logic [EXC_W-1:0]     exc_code;
    logic [31:0]          epc;

    logic [IRQ_COUNT-1:0] rise;
    logic [IRQ_COUNT-1:0] masked;
    logic [IRQ_COUNT-1:0] win;
    logic [IRQ_COUNT-1:0] pending_d;
    logic                 irq_take;
    logic [31:0]          status_word;
    logic [31:0]          cause_word;

    irq_sync_edge #(.WIDTH(IRQ_COUNT)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (irq),
        .rise_c   (rise)
    );

    // Lowest-indexed enabled pending source wins (isolate lowest set bit).
    assign masked   = pending & im;
    assign win      = masked & (~masked + IRQ_COUNT'(1));
    assign irq_take = instrValid & ie & (|masked) & ~syscall & ~eret & ~mtc0;

    assign trap       = instrValid & (syscall | irq_take | eret);
    assign trapTarget = (instrValid & eret & ~syscall) ? epc : HANDLER_ADDR;
    assign inHandler  = (state == ST_HANDLER);

    always_comb begin
        status_word = '0;
        status_word[STATUS_IE] = ie;
        status_word[IM_LSB +: IRQ_COUNT] = im;
        cause_word = '0;
        cause_word[IM_LSB +: IRQ_COUNT] = pending;
        cause_word[EXC_LSB +: EXC_W] = exc_code;
        readData = '0;
        if (mfc0) begin
            case (cp0Addr)
                CP0_STATUS: readData = status_word;
                CP0_CAUSE:  readData = cause_word;
                CP0_EPC:    readData = epc;
                default:    readData = '0;
            endcase
        end
    end

    // A newly detected edge always survives a same-cycle clear.
    always_comb begin
        pending_d = pending;
        if (instrValid && mtc0 && (cp0Addr == CP0_CAUSE)) begin
            pending_d = writeData[IM_LSB +: IRQ_COUNT];
        end
        if (irq_take) begin
            pending_d = pending_d & ~win;
        end
        pending_d = pending_d | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            ie       <= 1'b0;
            im       <= '0;
            pending  <= '0;
            exc_code <= EXC_INT;
            epc      <= '0;
        end else begin
            pending <= pending_d;
            if (instrValid) begin
                if (mtc0 && (cp0Addr == CP0_STATUS)) begin
                    ie <= writeData[STATUS_IE];
                    im <= writeData[IM_LSB +: IRQ_COUNT];
                end
                if (mtc0 && (cp0Addr == CP0_EPC)) begin
                    epc <= writeData;
                end
                if (syscall) begin
                    epc      <= pcNext;
                    exc_code <= EXC_SYS;
                    ie       <= 1'b0;
                    state    <= ST_HANDLER;
                end else if (irq_take) begin
                    epc      <= pcNext;
                    exc_code <= EXC_INT;
                    ie       <= 1'b0;
                    state    <= ST_HANDLER;
                end else if (eret) begin
                    ie    <= 1'b1;
                    state <= ST_RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_trap_unit.sv
// Directed vector table plus randomized traffic checked against a behavioural CP0 model.
module tb_cp0_trap_unit;

    localparam int unsigned N = 3;
    localparam logic [31:0] H = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst, instrValid, mtc0, mfc0, eret, syscall;
    logic [4:0]  cp0Addr;
    logic [31:0] writeData, pcNext;
    logic [N-1:0] irq;
    logic [31:0] readData, trapTarget;
    logic        trap, inHandler;

    always #5 clk = ~clk;

    cp0_trap_unit #(.IRQ_COUNT(N), .HANDLER_ADDR(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .instrValid (instrValid),
        .mtc0       (mtc0),
        .mfc0       (mfc0),
        .eret       (eret),
        .syscall    (syscall),
        .cp0Addr    (cp0Addr),
        .writeData  (writeData),
        .pcNext     (pcNext),
        .irq        (irq),
        .readData   (readData),
        .trap       (trap),
        .trapTarget (trapTarget),
        .inHandler  (inHandler)
    );

    typedef struct {
        logic        r, iv, wr, rd, er, sc;
        logic [4:0]  a;
        logic [31:0] wd, pc;
        logic [N-1:0] irq;
        logic        et;
        logic [31:0] etg, erd;
        logic        einh;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic         m_ie, m_inh;
    logic [N-1:0] m_im, m_pend;
    logic [4:0]   m_exc;
    logic [31:0]  m_epc;
    logic [N-1:0] hist [3];

    function automatic vec_t mk(logic r, logic iv, logic wr, logic rd, logic er, logic sc,
                                logic [4:0] a, logic [31:0] wd, logic [31:0] pc, logic [N-1:0] q,
                                logic et, logic [31:0] etg, logic [31:0] erd, logic einh);
        vec_t v;
        v.r = r; v.iv = iv; v.wr = wr; v.rd = rd; v.er = er; v.sc = sc;
        v.a = a; v.wd = wd; v.pc = pc; v.irq = q;
        v.et = et; v.etg = etg; v.erd = erd; v.einh = einh;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ie = 0; m_inh = 0; m_im = '0; m_pend = '0; m_exc = 5'd0; m_epc = '0;
        for (int i = 0; i < 3; i++) hist[i] = '0;
    endtask

    // Expected combinational outputs from the current model state and this cycle's inputs.
    function automatic vec_t model_expect(vec_t v);
        vec_t o = v;
        logic take;
        take = v.iv && m_ie && ((m_pend & m_im) != 0) && !v.sc && !v.er && !v.wr;
        o.et = v.iv && (v.sc || take || v.er);
        o.etg = (v.iv && v.er) ? m_epc : H;
        case (v.a)
            5'd12: o.erd = (32'(m_im) << 8) | 32'(m_ie);
            5'd13: o.erd = (32'(m_pend) << 8) | (32'(m_exc) << 2);
            5'd14: o.erd = m_epc;
            default: o.erd = 32'd0;
        endcase
        o.einh = m_inh;
        return o;
    endfunction

    task automatic model_step(input vec_t v);
        logic [N-1:0] rise, en, np;
        logic take;
        int w;
        if (v.r) begin
            model_reset();
            return;
        end
        // Edge seen by the detector: irq two samples ago high, three samples ago low.
        rise = hist[1] & ~hist[2];
        hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = v.irq;
        en = m_pend & m_im;
        take = v.iv && m_ie && (en != 0) && !v.sc && !v.er && !v.wr;
        np = m_pend;
        if (v.iv) begin
            if (v.wr) begin
                if (v.a == 5'd12) begin m_ie = v.wd[0]; m_im = v.wd[10:8]; end
                if (v.a == 5'd13) np = v.wd[10:8];
                if (v.a == 5'd14) m_epc = v.wd;
            end
            if (v.sc) begin
                m_epc = v.pc; m_exc = 5'd8; m_ie = 0; m_inh = 1;
            end else if (take) begin
                w = -1;
                for (int i = 0; i < N; i++) if (en[i] && w < 0) w = i;
                np[w] = 1'b0;
                m_epc = v.pc; m_exc = 5'd0; m_ie = 0; m_inh = 1;
            end else if (v.er) begin
                m_ie = 1; m_inh = 0;
            end
        end
        m_pend = np | rise;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst = v.r; instrValid = v.iv; mtc0 = v.wr; mfc0 = v.rd; eret = v.er; syscall = v.sc;
        cp0Addr = v.a; writeData = v.wd; pcNext = v.pc; irq = v.irq;
        #2;
        chk("trap", idx, 32'(trap), 32'(v.et));
        if (v.et || !v.er) chk("trapTarget", idx, trapTarget, v.etg);
        if (v.rd) chk("readData", idx, readData, v.erd);
        chk("inHandler", idx, 32'(inHandler), 32'(v.einh));
        @(posedge clk);
        model_step(v);
    endtask

    vec_t tbl[$];
    vec_t rv;
    logic [N-1:0] cur_irq;
    int op;

    initial begin
        rst = 1; instrValid = 0; mtc0 = 0; mfc0 = 0; eret = 0; syscall = 0;
        cp0Addr = '0; writeData = '0; pcNext = '0; irq = '0;
        repeat (2) @(posedge clk);
        model_reset();

        //             r iv wr rd er sc addr wd           pc     irq     trap tgt     rd            inh
        tbl.push_back(mk(0,1,0,1,0,0,5'd12,32'h0,       32'h0, 3'b000, 0, H,      32'h0,       0));
        tbl.push_back(mk(0,1,0,1,0,0,5'd13,32'h0,       32'h0, 3'b000, 0, H,      32'h0,       0));
        tbl.push_back(mk(0,1,0,1,0,0,5'd14,32'h0,       32'h0, 3'b000, 0, H,      32'h0,       0));
        tbl.push_back(mk(0,1,1,1,0,0,5'd12,32'h301,     32'h4, 3'b010, 0, H,      32'h0,       0));
        tbl.push_back(mk(0,1,0,1,0,0,5'd12,32'h0,       32'h8, 3'b010, 0, H,      32'h301,     0));
        tbl.push_back(mk(0,1,0,0,0,0,5'd0, 32'h0,       32'hC, 3'b010, 0, H,      32'h0,       0));
        tbl.push_back(mk(0,1,0,1,0,0,5'd13,32'h0,       32'h40,3'b010, 1, H,      32'h200,     0));
        tbl.push_back(mk(0,1,0,1,0,0,5'd14,32'h0,       32'h44,3'b010, 0, H,      32'h40,      1));
        tbl.push_back(mk(0,1,0,1,0,0,5'd13,32'h0,       32'h48,3'b010, 0, H,      32'h0,       1));
        tbl.push_back(mk(0,1,0,1,0,0,5'd12,32'h0,       32'h4C,3'b010, 0, H,      32'h300,     1));
        tbl.push_back(mk(0,1,0,0,0,0,5'd0, 32'h0,       32'h0, 3'b001, 0, H,      32'h0,       1));
        tbl.push_back(mk(0,1,0,0,0,0,5'd0, 32'h0,       32'h0, 3'b001, 0, H,      32'h0,       1));
        tbl.push_back(mk(0,1,0,0,0,0,5'd0, 32'h0,       32'h0, 3'b001, 0, H,      32'h0,       1));
        tbl.push_back(mk(0,1,0,0,1,0,5'd0, 32'h0,       32'h0, 3'b001, 1, 32'h40, 32'h0,       1));
        tbl.push_back(mk(0,1,0,1,0,1,5'd13,32'h0,       32'h1C,3'b001, 1, H,      32'h100,     0));
        tbl.push_back(mk(0,1,0,1,0,0,5'd13,32'h0,       32'h20,3'b001, 0, H,      32'h120,     1));
        tbl.push_back(mk(0,1,0,1,1,0,5'd14,32'h0,       32'h0, 3'b001, 1, 32'h1C, 32'h1C,      1));
        tbl.push_back(mk(0,1,0,1,0,0,5'd12,32'h0,       32'h50,3'b001, 1, H,      32'h301,     0));
        tbl.push_back(mk(0,1,0,1,0,0,5'd13,32'h0,       32'h0, 3'b000, 0, H,      32'h0,       1));
        tbl.push_back(mk(0,1,1,1,0,0,5'd12,32'h501,     32'h0, 3'b000, 0, H,      32'h300,     1));
        tbl.push_back(mk(0,1,0,1,0,0,5'd14,32'h0,       32'h0, 3'b000, 0, H,      32'h50,      1));
        tbl.push_back(mk(0,1,0,0,0,0,5'd0, 32'h0,       32'h0, 3'b101, 0, H,      32'h0,       1));
        tbl.push_back(mk(0,1,0,0,0,0,5'd0, 32'h0,       32'h0, 3'b101, 0, H,      32'h0,       1));
        tbl.push_back(mk(0,1,0,0,0,0,5'd0, 32'h0,       32'h0, 3'b101, 0, H,      32'h0,       1));
        tbl.push_back(mk(0,1,0,0,0,0,5'd0, 32'h0,       32'h60,3'b101, 1, H,      32'h0,       1));
        tbl.push_back(mk(0,1,0,1,0,0,5'd13,32'h0,       32'h0, 3'b101, 0, H,      32'h400,     1));
        tbl.push_back(mk(0,1,0,0,1,0,5'd0, 32'h0,       32'h0, 3'b101, 1, 32'h60, 32'h0,       1));
        tbl.push_back(mk(0,1,0,0,0,0,5'd0, 32'h0,       32'h70,3'b101, 1, H,      32'h0,       0));
        tbl.push_back(mk(0,1,0,1,0,0,5'd14,32'h0,       32'h0, 3'b111, 0, H,      32'h70,      1));
        tbl.push_back(mk(0,1,0,0,0,0,5'd0, 32'h0,       32'h0, 3'b111, 0, H,      32'h0,       1));
        tbl.push_back(mk(0,1,1,1,0,0,5'd13,32'h0,       32'h0, 3'b111, 0, H,      32'h0,       1));
        tbl.push_back(mk(0,1,0,1,0,0,5'd13,32'h0,       32'h0, 3'b111, 0, H,      32'h200,     1));
        tbl.push_back(mk(0,0,1,0,1,0,5'd14,32'hDEAD,    32'h0, 3'b111, 0, H,      32'h0,       1));
        tbl.push_back(mk(0,1,0,1,0,0,5'd14,32'h0,       32'h0, 3'b111, 0, H,      32'h70,      1));
        tbl.push_back(mk(0,1,1,1,0,0,5'd5, 32'hFFFFFFFF,32'h0, 3'b111, 0, H,      32'h0,       1));
        tbl.push_back(mk(1,1,0,0,0,0,5'd0, 32'h0,       32'h0, 3'b111, 0, H,      32'h0,       1));
        tbl.push_back(mk(0,1,0,1,0,0,5'd12,32'h0,       32'h0, 3'b111, 0, H,      32'h0,       0));
        tbl.push_back(mk(0,1,0,1,0,0,5'd13,32'h0,       32'h0, 3'b111, 0, H,      32'h0,       0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        cur_irq = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) cur_irq[b] = ~cur_irq[b];
            op = int'($urandom_range(7));
            rv = mk(($urandom_range(199) == 0), ($urandom_range(4) != 0), 0, 0, 0, 0,
                    ($urandom_range(3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(2)),
                    $urandom, $urandom & 32'hFFFF_FFFC, cur_irq, 0, H, 0, 0);
            case (op)
                1: rv.wr = 1;
                2: rv.rd = 1;
                3: rv.er = 1;
                4: rv.sc = 1;
                5: begin rv.wr = 1; rv.rd = 1; end
                default: ;
            endcase
            rv = model_expect(rv);
            apply(rv, 1000 + i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cp0_trap_unit.md
# cp0_trap_unit

Coprocessor-0 responder for the single-cycle MIPS core. It executes the `mtc0`/`mfc0`/`eret`/`syscall` control bits that the instruction decoder raises. It owns Status, Cause and EPC, synchronises and latches external interrupt requests, and tells the PC logic when to redirect to the trap handler or back to EPC.

## Interface
Parameters:
- `IRQ_COUNT`, 3: number of external interrupt sources (1–8).
- `HANDLER_ADDR`, 32'h0000_0100: common trap vector.

Ports:
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `instrValid` in 1: current instruction retires this cycle. Low while the core is halted or stalled.
- `mtc0` in 1: write CP0 register `cp0Addr` with `writeData`.
- `mfc0` in 1: read CP0 register `cp0Addr` onto `readData`.
- `eret` in 1: return from trap.
- `syscall` in 1: synchronous syscall trap.
- `cp0Addr` in 5: CP0 register number (`instruction[15:11]`).
- `writeData` in 32: GPR rt value for `mtc0`.
- `pcNext` in 32: sequential next-PC of the retiring instruction (PC+4).
- `irq` in IRQ_COUNT: asynchronous level interrupt requests (board buttons).
- `readData` out 32: CP0 read value.
- `trap` out 1: redirect PC to `trapTarget` at the next edge.
- `trapTarget` out 32: `HANDLER_ADDR` when trapping, EPC on `eret`.
- `inHandler` out 1: state is HANDLER.

## Operation
- Registers:
  - Status (12): bit0 IE; bits [8+IRQ_COUNT-1:8] IM mask.
  - Cause (13): bits [8+IRQ_COUNT-1:8] pending; bits [6:2] ExcCode (0 = interrupt, 8 = syscall).
  - EPC (14): full 32 bits.
- Other addresses read 0; writes to them are ignored. Unimplemented bits read 0.
- `irq` passes through a 2-flop synchroniser, then a rising-edge detector. A detected edge sets the matching pending bit.
- `irqTake` = `instrValid` & IE & |(pending & IM) & !`syscall` & !`eret` & !`mtc0`.
- Winning source: the lowest-indexed set bit of pending & IM.
- `trap` = `instrValid` & (`syscall` | `irqTake` | `eret`), combinational.
- On syscall:
  - EPC←`pcNext`, ExcCode←8, IE←0, state→HANDLER.
  - Syscall has priority over any pending interrupt in the same cycle.
- On irqTake:
  - EPC←`pcNext`, ExcCode←0, IE←0, the winning pending bit clears, state→HANDLER.
- On `eret`:
  - `trapTarget`=EPC, IE←1, state→RUN.
  - An `eret` while already in RUN still restores IE and jumps.
- On `mtc0`:
  - Status: IE/IM written.
  - Cause: pending written; ExcCode is read-only.
  - EPC: fully written.
- `mfc0` is combinational. A read in the same cycle as an `mtc0` to the same register returns the old value.
- State machine:
  - States RUN and HANDLER; reset → RUN.
  - RUN→HANDLER on syscall or irqTake.
  - HANDLER→RUN on `eret`.
  - Nested traps are blocked only by IE=0. Software that sets IE inside the handler permits nesting; state stays HANDLER.

## Timing
- Reset values: Status=0, Cause=0, EPC=0, synchroniser/edge flops=0, state=RUN.
- Reset output values: `trap`=0, `readData`=0, `trapTarget`=`HANDLER_ADDR`, `inHandler`=0.
- Irq-edge-to-pending latency: 3 clocks. Sampled at 2 synchroniser edges, then the edge detect registers pending on the 3rd.
- The first retiring instruction after pending is visible can trap. The PC equals `HANDLER_ADDR` one edge after `trap`.
- Edge and clear of the same pending bit in one cycle (acceptance or `mtc0` write of 0): set wins.
- `instrValid`=0: no register or state update except synchroniser and pending-set.
- Reset mid-handler: all state is discarded and the unit returns to RUN with IE=0.

## Structure
- Shared package `cp0_pkg`:
  - Register addresses `CP0_STATUS`=12, `CP0_CAUSE`=13, `CP0_EPC`=14.
  - `EXC_INT`=0, `EXC_SYS`=8.
  - Bit positions `STATUS_IE`=0, `IM_LSB`=8, `EXC_LSB`=2.
  - State enum.
- Sub-module `irq_sync_edge` (per-bit 2-flop synchroniser plus rising-edge detect, width-parameterised).
- Priority pick and register file stay in the top module.

## Test plan
- Reset, then `mfc0` of 12/13/14 → `readData` 0 for each; `trap`=0, `inHandler`=0.
- `mtc0` Status←32'h0000_0301, hold `irq[1]` high, `pcNext`=32'h40:
  - `trap`=1 three cycles later with `trapTarget`=32'h100.
  - Then EPC=32'h40, Cause=32'h0 (pending[1] cleared), IE=0, `inHandler`=1.
- `syscall` with `pcNext`=32'h1C and `irq[0]` pending plus enabled, same cycle:
  - Syscall wins; Cause[6:2]=8; pending[0] still set.
  - Next cycle no interrupt is taken because IE=0.
- `eret` in HANDLER with EPC=32'h1C → `trapTarget`=32'h1C, `trap`=1. Next cycle IE=1 and the pending irq[0] is taken immediately.
- `irq[0]` and `irq[2]` edges together, mask 3'b101, IE=1:
  - irq0 is taken first.
  - After `eret`, irq2 is taken; EPC holds each `pcNext`.
- `mtc0` Cause←0 in the same cycle that an `irq[1]` edge is registered → pending[1]=1 afterwards (set wins).
